// File: rtl/spc_spy_reader.sv
// Debug-side reader for the SPC return stack: snapshots spcptr on start and streams
// DEPTH entries downward from top-of-stack over a valid/ready handshake, without disturbing the stack.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | requesting the RAM read port; read issued when granted
// READ  | RAM data returning; lost grant sends us back to re-read
// CAPT  | register {offset, entry} onto the output
// SEND  | holding out_data until the consumer accepts
module spc_spy_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 19
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          depth,
  input  logic [ADDR_W-1:0]          spcptr,
  output logic                       req,
  input  logic                       grant,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_en,
  input  logic [DATA_W-1:0]          rd_data,
  output logic [ADDR_W+DATA_W-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_CAPT, S_SEND} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] OFS_ONE  = ADDR_W'(1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   offset;
  logic [ADDR_W:0]     count;
  logic [DATA_W-1:0]   data_q;
  logic                launch;
  logic                accept;
  logic                last;

  // A start landing in the done cycle is treated as arriving while still busy.
  assign launch  = (state == S_IDLE) && start && !done;
  assign accept  = (state == S_SEND) && out_ready;
  assign last    = (count == CNT_ONE);
  assign rd_addr = base - offset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch) state_nxt = S_REQ;
      end
      S_REQ: begin
        req = 1'b1;
        if (grant) begin
          rd_en     = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        req       = 1'b1;
        state_nxt = grant ? S_CAPT : S_REQ;
      end
      S_CAPT: begin
        req       = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (out_ready) state_nxt = last ? S_IDLE : S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base      <= '0;
      offset    <= '0;
      count     <= '0;
      data_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        base   <= spcptr;
        count  <= (depth == '0) ? CNT_FULL : {1'b0, depth};
        offset <= '0;
        busy   <= 1'b1;
      end
      if (state == S_READ && grant) data_q <= rd_data;
      if (state == S_CAPT) begin
        out_data  <= {offset, data_q};
        out_valid <= 1'b1;
      end
      if (accept) begin
        out_valid <= 1'b0;
        offset    <= offset + OFS_ONE;
        count     <= count - CNT_ONE;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spc_spy_reader.sv
// Bench for spc_spy_reader: a RAM model plus a queue of expected {offset, entry} words
// built from the snapshot pointer and depth, checked against the streamed output.
module tb_spc_spy_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  depth;
  logic [4:0]  spcptr;
  logic        req;
  logic        grant;
  logic [4:0]  rd_addr;
  logic        rd_en;
  logic [18:0] rd_data = '0;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [18:0] mem [32];
  int n_vec = 0;
  int n_err = 0;

  spc_spy_reader #(.ADDR_W(5), .DATA_W(19)) dut (
    .clk(clk), .reset(reset), .start(start), .depth(depth), .spcptr(spcptr),
    .req(req), .grant(grant), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gmode: 0 grant always, 1 random grant, 2 drop grant once in READ for offset 1
  // rmode: 0 ready always, 1 random ready, 2 ready only after 10 valid cycles
  task automatic run_dump(input int b, input int d, input int gmode, input int rmode, input bit noise);
    int dd, n_acc, reads, done_cnt, first_valid, vcyc, last_acc, rd1;
    bit drop_next, fin;
    logic [23:0] held;
    logic [23:0] exp_q[$];
    dd = (d == 0) ? 32 : d;
    n_acc = 0; reads = 0; done_cnt = 0; first_valid = -1; vcyc = 0; last_acc = -1; rd1 = 0;
    drop_next = 1'b0; fin = 1'b0; held = '0;
    for (int i = 0; i < dd; i++) begin
      int a;
      a = (b - i) & 31;
      exp_q.push_back({i[4:0], mem[a]});
    end
    @(negedge clk);
    spcptr = 5'(b); depth = 5'(d); start = 1'b1; grant = 1'b1; out_ready = (rmode == 0);
    for (int cyc = 1; cyc <= 1500 && !fin; cyc++) begin
      @(negedge clk);
      start = noise && ($urandom_range(0, 3) == 0);
      if (noise) spcptr = 5'($urandom);
      case (gmode)
        0:       grant = 1'b1;
        1:       grant = ($urandom_range(0, 3) != 0);
        default: grant = !drop_next;
      endcase
      drop_next = 1'b0;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (vcyc >= 10);
      endcase
      #1;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (rd_en) begin
        reads++;
        chk("rd_addr", rd_addr, (b - n_acc) & 31);
        if (gmode == 2 && n_acc == 1 && rd1 == 0) begin
          rd1 = 1;
          drop_next = 1'b1;
        end
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (vcyc == 0) held = out_data;
        else begin
          chk("out_data_hold", out_data, held);
          chk("rd_en_in_send", rd_en, 0);
        end
        if (out_ready) begin
          if (n_acc < dd) chk("out_data", out_data, exp_q[n_acc]);
          else            chk("extra_entry", n_acc, dd - 1);
          if (gmode == 0 && rmode == 0 && last_acc >= 0) chk("throughput", cyc - last_acc, 4);
          last_acc = cyc;
          n_acc++;
          vcyc = 0;
        end else vcyc++;
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
      end
    end
    chk("done_seen", done_cnt, 1);
    chk("entries", n_acc, dd);
    chk("busy_at_done", busy, 0);
    if (gmode != 1) chk("read_count", reads, dd + ((gmode == 2) ? 1 : 0));
    if (gmode == 0 && rmode == 0) chk("latency", first_valid, 4);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("req_idle", req, 0);
    chk("valid_idle", out_valid, 0);
  endtask

  initial begin
    int waited;
    reset = 1'b1; start = 1'b0; depth = '0; spcptr = '0; grant = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 32; k++) mem[k] = 19'(k * 'h101);
    run_dump(5, 3, 0, 0, 0);
    run_dump(1, 4, 0, 0, 0);
    run_dump(31, 0, 0, 0, 0);
    run_dump(10, 3, 2, 0, 0);
    run_dump(7, 3, 0, 2, 1);

    for (int k = 0; k < 32; k++) mem[k] = 19'($urandom);
    for (int r = 0; r < 6; r++)
      run_dump($urandom_range(0, 31), $urandom_range(0, 31), 1, 1, 1);
    run_dump(2, 4, 1, 2, 1);

    @(negedge clk);
    spcptr = 5'd3; depth = 5'd5; start = 1'b1; grant = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("valid_before_reset", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req", req, 0);
    chk("arst_rd_en", rd_en, 0);
    chk("arst_rd_addr", rd_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    run_dump(3, 2, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
